writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/wb_pkg.sv | 25 ++
 rtl/wb_chan_fifo.sv | 55 +++++
 rtl/writeback_arbiter.sv | 140 ++++++++++++++
 tb/tb_writeback_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and default widths for the writeback arbiter and its channel buffers.
package wb_pkg;

   localparam int WB_DATA_WIDTH = 32;
   localparam int WB_PHY_WIDTH  = 6;
   localparam int WB_ROB_WIDTH  = 5;
   localparam int WB_BUF_DEPTH  = 4;

   // One execution result as it travels from a channel to a writeback port.
   // Field order here is also the packing order of the flat entry vectors.
   typedef struct packed {
      logic [WB_ROB_WIDTH-1:0]  rob_id;
      logic [WB_PHY_WIDTH-1:0]  rd_phy;
      logic                     rd_we;
      logic [WB_DATA_WIDTH-1:0] data;
   } wb_entry_t;

   localparam int WB_ENTRY_WIDTH = $bits(wb_entry_t);

   // Width of a packed entry for non-default field widths.
   function automatic int wb_entry_width(input int rob_w, input int phy_w, input int data_w);
      return rob_w + phy_w + 1 + data_w;
   endfunction

endpackage

// File: rtl/wb_chan_fifo.sv
// Per-channel result buffer: power-of-two FIFO with registered occupancy.
// Flush and reset both empty the buffer; stored data is never cleared.
module wb_chan_fifo
   import wb_pkg::*;
#(
   parameter int WIDTH = WB_ENTRY_WIDTH,
   parameter int DEPTH = WB_BUF_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       enq,
   input  logic [WIDTH-1:0]           enq_data,
   input  logic                       deq,
   output logic [WIDTH-1:0]           deq_data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
         if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({enq, deq})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Payload storage; a write during flush/reset is harmless since the pointers restart.
   always_ff @(posedge clk) begin
      if (enq) mem[wr_ptr] <= enq_data;
   end

   assign deq_data = mem[rd_ptr];
   assign full     = (count == FULL_CNT);
   assign empty    = (count == '0);

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: buffers results from NUM_CH execution channels and
// drains up to NUM_WB of them per cycle onto registered writeback ports,
// round-robin from rr_ptr, at most one entry per channel per cycle.
module writeback_arbiter
   import wb_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int NUM_WB     = 2,
   parameter int DATA_WIDTH = WB_DATA_WIDTH,
   parameter int PHY_WIDTH  = WB_PHY_WIDTH,
   parameter int ROB_WIDTH  = WB_ROB_WIDTH,
   parameter int BUF_DEPTH  = WB_BUF_DEPTH
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      flush,
   input  logic [NUM_CH-1:0]                         in_valid,
   output logic [NUM_CH-1:0]                         in_ready,
   input  logic [NUM_CH*ROB_WIDTH-1:0]               in_rob_id,
   input  logic [NUM_CH*PHY_WIDTH-1:0]               in_rd_phy,
   input  logic [NUM_CH-1:0]                         in_rd_we,
   input  logic [NUM_CH*DATA_WIDTH-1:0]              in_data,
   output logic [NUM_WB-1:0]                         out_valid,
   output logic [NUM_WB*ROB_WIDTH-1:0]               out_rob_id,
   output logic [NUM_WB*PHY_WIDTH-1:0]               out_rd_phy,
   output logic [NUM_WB-1:0]                         out_rd_we,
   output logic [NUM_WB*DATA_WIDTH-1:0]              out_data,
   output logic [NUM_CH*$clog2(BUF_DEPTH+1)-1:0]     buf_count
);

   localparam int ENT_W = wb_entry_width(ROB_WIDTH, PHY_WIDTH, DATA_WIDTH);
   localparam int CNT_W = $clog2(BUF_DEPTH + 1);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0]   fifo_full;
   logic [NUM_CH-1:0]   fifo_empty;
   logic [NUM_CH-1:0]   enq;
   logic [NUM_CH-1:0]   grant;
   logic [ENT_W-1:0]    head [NUM_CH];
   logic [CNT_W-1:0]    cnt  [NUM_CH];

   logic [CH_W-1:0]     rr_ptr;
   logic [CH_W-1:0]     rr_next;
   logic [NUM_WB-1:0]   port_vld;
   logic [CH_W-1:0]     port_ch [NUM_WB];
   logic [2*NUM_CH-1:0] req_dbl;
   logic [2*NUM_CH-1:0] gnt_dbl;
   logic [NUM_CH-1:0]   req_rot;
   logic [NUM_CH-1:0]   gnt_rot;

   logic [NUM_WB-1:0]   out_vld_p1;
   logic [ENT_W-1:0]    out_ent_p1 [NUM_WB];

   // Channel buffers; acceptance depends only on the registered count.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
      assign enq[c]      = in_valid[c] & ~fifo_full[c] & ~flush;
      assign in_ready[c] = ~fifo_full[c];
      assign buf_count[c*CNT_W +: CNT_W] = cnt[c];

      wb_chan_fifo #(
         .WIDTH (ENT_W),
         .DEPTH (BUF_DEPTH)
      ) u_fifo (
         .clk      (clk),
         .rst      (rst),
         .flush    (flush),
         .enq      (enq[c]),
         .enq_data ({in_rob_id[c*ROB_WIDTH +: ROB_WIDTH],
                     in_rd_phy[c*PHY_WIDTH +: PHY_WIDTH],
                     in_rd_we[c],
                     in_data[c*DATA_WIDTH +: DATA_WIDTH]}),
         .deq      (grant[c]),
         .deq_data (head[c]),
         .count    (cnt[c]),
         .full     (fifo_full[c]),
         .empty    (fifo_empty[c])
      );
   end

   // Round-robin grant: rotate requests so rr_ptr is bit 0, take the first
   // NUM_WB set bits in order (k-th grant -> port k), then rotate back.
   always_comb begin
      int gcnt;
      int ch;
      gcnt     = 0;
      ch       = 0;
      gnt_rot  = '0;
      port_vld = '0;
      rr_next  = rr_ptr;
      for (int k = 0; k < NUM_WB; k++) port_ch[k] = '0;

      req_dbl = {~fifo_empty, ~fifo_empty} >> rr_ptr;
      req_rot = req_dbl[NUM_CH-1:0];

      for (int i = 0; i < NUM_CH; i++) begin
         if (req_rot[i] && (gcnt < NUM_WB)) begin
            ch = int'(rr_ptr) + i;
            if (ch >= NUM_CH) ch = ch - NUM_CH;
            gnt_rot[i] = 1'b1;
            for (int k = 0; k < NUM_WB; k++) begin
               if (k == gcnt) begin
                  port_vld[k] = 1'b1;
                  port_ch[k]  = CH_W'(ch);
               end
            end
            rr_next = (ch == NUM_CH - 1) ? '0 : CH_W'(ch + 1);
            gcnt    = gcnt + 1;
         end
      end

      gnt_dbl = {gnt_rot, gnt_rot} << rr_ptr;
      grant   = gnt_dbl[2*NUM_CH-1:NUM_CH];
   end

   // Writeback port registers and round-robin pointer; flush drops this cycle's grants.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld_p1 <= '0;
         rr_ptr     <= '0;
         for (int k = 0; k < NUM_WB; k++) out_ent_p1[k] <= '0;
      end else if (flush) begin
         out_vld_p1 <= '0;
         rr_ptr     <= '0;
      end else begin
         out_vld_p1 <= port_vld;
         rr_ptr     <= rr_next;
         for (int k = 0; k < NUM_WB; k++)
            out_ent_p1[k] <= port_vld[k] ? head[port_ch[k]] : '0;
      end
   end

   for (genvar k = 0; k < NUM_WB; k++) begin : g_port
      assign out_valid[k]                          = out_vld_p1[k];
      assign out_rob_id[k*ROB_WIDTH +: ROB_WIDTH]  = out_ent_p1[k][ENT_W-1 -: ROB_WIDTH];
      assign out_rd_phy[k*PHY_WIDTH +: PHY_WIDTH]  = out_ent_p1[k][DATA_WIDTH+1 +: PHY_WIDTH];
      assign out_rd_we[k]                          = out_ent_p1[k][DATA_WIDTH];
      assign out_data[k*DATA_WIDTH +: DATA_WIDTH]  = out_ent_p1[k][DATA_WIDTH-1:0];
   end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter with a queue-based reference model.
module tb_writeback_arbiter;

   localparam int NCH = 4;
   localparam int NWB = 2;
   localparam int DW  = 32;
   localparam int PW  = 6;
   localparam int RW  = 5;
   localparam int DEP = 4;
   localparam int EW  = RW + PW + 1 + DW;

   logic            clk = 1'b0;
   logic            rst;
   logic            flush;
   logic [NCH-1:0]  in_valid;
   logic [NCH-1:0]  in_ready;
   logic [NCH*RW-1:0] in_rob_id;
   logic [NCH*PW-1:0] in_rd_phy;
   logic [NCH-1:0]    in_rd_we;
   logic [NCH*DW-1:0] in_data;
   logic [NWB-1:0]    out_valid;
   logic [NWB*RW-1:0] out_rob_id;
   logic [NWB*PW-1:0] out_rd_phy;
   logic [NWB-1:0]    out_rd_we;
   logic [NWB*DW-1:0] out_data;
   logic [NCH*3-1:0]  buf_count;

   writeback_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_rob_id  (in_rob_id),
      .in_rd_phy  (in_rd_phy),
      .in_rd_we   (in_rd_we),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_rob_id (out_rob_id),
      .out_rd_phy (out_rd_phy),
      .out_rd_we  (out_rd_we),
      .out_data   (out_data),
      .buf_count  (buf_count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [EW-1:0] q [NCH][$];
   int            rr_m = 0;
   logic [NWB-1:0] exp_vld = '0;
   logic [EW-1:0]  exp_ent [NWB];
   bit            acc [NCH];
   bit            model_on = 0;

   task automatic model_step();
      int sz [NCH];
      int g;
      int last;
      if (rst) begin
         for (int c = 0; c < NCH; c++) begin q[c].delete(); acc[c] = 0; end
         exp_vld = '0;
         for (int k = 0; k < NWB; k++) exp_ent[k] = '0;
         rr_m = 0;
         model_on = 1;
      end else if (flush) begin
         for (int c = 0; c < NCH; c++) begin q[c].delete(); acc[c] = 0; end
         exp_vld = '0;
         rr_m = 0;
      end else begin
         g = 0;
         last = 0;
         exp_vld = '0;
         for (int c = 0; c < NCH; c++) sz[c] = q[c].size();
         for (int i = 0; i < NCH; i++) begin
            int ch;
            ch = (rr_m + i) % NCH;
            if (sz[ch] > 0 && g < NWB) begin
               exp_ent[g] = q[ch].pop_front();
               exp_vld[g] = 1'b1;
               g++;
               last = ch;
            end
         end
         for (int c = 0; c < NCH; c++) begin
            acc[c] = in_valid[c] && (sz[c] < DEP);
            if (acc[c])
               q[c].push_back({in_rob_id[c*RW +: RW], in_rd_phy[c*PW +: PW],
                               in_rd_we[c], in_data[c*DW +: DW]});
         end
         if (g > 0) rr_m = (last + 1) % NCH;
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // ---------------- per-cycle compare ----------------
   bit cmp_en = 0;
   bit count_en = 0;
   bit ord_en = 0;
   bit saw_full = 0;
   bit saw_f1 = 0;
   int gcount [16];
   int next2 = 0;

   function automatic logic [EW-1:0] dut_ent(input int k);
      return {out_rob_id[k*RW +: RW], out_rd_phy[k*PW +: PW], out_rd_we[k], out_data[k*DW +: DW]};
   endfunction

   initial begin
      for (int i = 0; i < 16; i++) gcount[i] = 0;
      forever begin
         @(negedge clk);
         if (model_on && cmp_en) begin
            logic [NCH*3-1:0] exp_cnt;
            logic [NCH-1:0]   exp_rdy;
            check("out_valid", 64'(out_valid), 64'(exp_vld));
            for (int k = 0; k < NWB; k++)
               if (exp_vld[k]) check($sformatf("port%0d_payload", k), 64'(dut_ent(k)), 64'(exp_ent[k]));
            for (int c = 0; c < NCH; c++) begin
               exp_cnt[c*3 +: 3] = 3'(q[c].size());
               exp_rdy[c] = (q[c].size() != DEP);
            end
            check("buf_count", 64'(buf_count), 64'(exp_cnt));
            check("in_ready", 64'(in_ready), 64'(exp_rdy));
            if (!in_ready[2]) saw_full = 1;
            for (int k = 0; k < NWB; k++)
               if (out_valid[k] && out_data[k*DW +: DW] == 32'hF1F1_F1F1) saw_f1 = 1;
            if (count_en) begin
               for (int k = 0; k < NWB; k++)
                  if (out_valid[k]) gcount[out_data[k*DW+28 +: 4]]++;
               if (out_valid == 2'b11)
                  check("distinct_ch", 64'(out_data[31:28] != out_data[63:60]), 64'd1);
            end
            if (ord_en) begin
               for (int k = 0; k < NWB; k++)
                  if (out_valid[k] && out_data[k*DW+28 +: 4] == 4'd2) begin
                     check("ch2_order", 64'(out_data[k*DW +: 28]), 64'(next2));
                     next2++;
                  end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   int seq [NCH];

   task automatic set_ch(input int c, input logic [RW-1:0] rob, input logic [PW-1:0] phy,
                         input logic we, input logic [DW-1:0] d);
      in_rob_id[c*RW +: RW] = rob;
      in_rd_phy[c*PW +: PW] = phy;
      in_rd_we[c]           = we;
      in_data[c*DW +: DW]   = d;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Every channel in mask presents a new tagged entry each cycle; a new one only after acceptance.
   task automatic sat(input int cycles, input logic [NCH-1:0] mask);
      for (int n = 0; n < cycles; n++) begin
         for (int c = 0; c < NCH; c++)
            set_ch(c, RW'(seq[c]), PW'(c), seq[c][0], {4'(c), 28'(seq[c])});
         in_valid = mask;
         step();
         for (int c = 0; c < NCH; c++) if (acc[c]) seq[c]++;
      end
   endtask

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      in_valid = '0;
      in_rob_id = '0;
      in_rd_phy = '0;
      in_rd_we = '0;
      in_data = '0;
      for (int c = 0; c < NCH; c++) seq[c] = 0;
      step();
      step();
      rst = 1'b0;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_buf_count", 64'(buf_count), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'hF);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_rob_id", 64'(out_rob_id), 64'd0);
      cmp_en = 1;

      // single result on ch0
      set_ch(0, 5'd3, 6'd7, 1'b1, 32'h0000_DEAD);
      in_valid = 4'b0001;
      step();
      in_valid = '0;
      check("single_count", 64'(buf_count[2:0]), 64'd1);
      check("single_not_yet", 64'(out_valid), 64'd0);
      step();
      check("single_valid", 64'(out_valid), 64'b01);
      check("single_rob", 64'(out_rob_id[4:0]), 64'd3);
      check("single_phy", 64'(out_rd_phy[5:0]), 64'd7);
      check("single_we", 64'(out_rd_we[0]), 64'd1);
      check("single_data", 64'(out_data[31:0]), 64'h0000_DEAD);
      step();
      check("single_done", 64'(out_valid), 64'd0);

      // flush resets rr_ptr, then one entry on every channel
      flush = 1'b1;
      step();
      flush = 1'b0;
      for (int c = 0; c < NCH; c++) set_ch(c, RW'(8 + c), PW'(10 + c), 1'b0, 32'hA0 + c);
      in_valid = 4'hF;
      step();
      in_valid = '0;
      check("four_count", 64'(buf_count), 64'h249);
      step();
      check("four_v1", 64'(out_valid), 64'b11);
      check("four_p0a", 64'(out_data[31:0]), 64'hA0);
      check("four_p1a", 64'(out_data[63:32]), 64'hA1);
      check("four_we0", 64'(out_rd_we), 64'b00);
      step();
      check("four_v2", 64'(out_valid), 64'b11);
      check("four_p0b", 64'(out_data[31:0]), 64'hA2);
      check("four_p1b", 64'(out_data[63:32]), 64'hA3);
      step();
      check("four_idle", 64'(out_valid), 64'd0);

      // rr_ptr back at 0: ch0 must win port 0 over ch3
      set_ch(0, 5'd1, 6'd1, 1'b1, 32'hB0);
      set_ch(3, 5'd2, 6'd2, 1'b1, 32'hB3);
      in_valid = 4'b1001;
      step();
      in_valid = '0;
      step();
      check("rr_p0", 64'(out_data[31:0]), 64'hB0);
      check("rr_p1", 64'(out_data[63:32]), 64'hB3);
      step();

      // saturation: buffers fill, backpressure, FIFO order, fairness
      ord_en = 1;
      next2 = 0;
      sat(20, 4'hF);
      count_en = 1;
      sat(100, 4'hF);
      count_en = 0;
      ord_en = 0;
      check("ch2_saw_full", 64'(saw_full), 64'd1);
      for (int c = 0; c < NCH; c++)
         check($sformatf("fair_ch%0d", c), 64'(gcount[c] >= 49 && gcount[c] <= 51), 64'd1);

      // flush with buffered entries and a new ch1 result
      flush = 1'b1;
      in_valid = 4'b0010;
      set_ch(1, 5'd9, 6'd9, 1'b1, 32'hF1F1_F1F1);
      step();
      flush = 1'b0;
      in_valid = '0;
      check("flush_valid", 64'(out_valid), 64'd0);
      check("flush_count", 64'(buf_count), 64'd0);
      check("flush_ready", 64'(in_ready), 64'hF);
      step();
      step();
      step();
      check("flush_drop_ch1", 64'(saw_f1), 64'd0);

      // reset mid-operation
      sat(6, 4'hF);
      check("pre_rst_valid", 64'(out_valid), 64'b11);
      rst = 1'b1;
      step();
      rst = 1'b0;
      in_valid = '0;
      check("rst2_valid", 64'(out_valid), 64'd0);
      check("rst2_count", 64'(buf_count), 64'd0);
      check("rst2_ready", 64'(in_ready), 64'hF);
      check("rst2_data", 64'(out_data), 64'd0);
      step();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
